// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the scheduler FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1101;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; any opcode not listed behaves as ADD.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] result
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt;
    logic            less;

    assign shamt = op2[SH_W-1:0];
    assign less  = $signed(op1) < $signed(op2);

    always_comb begin
        result = op1 + op2;
        case (alu_op)
            ALU_AND: result = op1 & op2;
            ALU_OR:  result = op1 | op2;
            ALU_ADD: result = op1 + op2;
            ALU_SUB: result = op1 - op2;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, less};
            ALU_XOR: result = op1 ^ op2;
            ALU_SRL: result = op1 >> shamt;
            ALU_SLL: result = op1 << shamt;
            ALU_SRA: result = $signed(op1) >>> shamt;
            default: result = op1 + op2;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin arbiter sharing one ALU between two requesters, IDLE/EXEC/RESP sequencing.
// Define ALU_SCHED_STATS_EN to compile in the per-requester grant counters.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0][WIDTH-1:0] req_op1,
    input  logic [1:0][WIDTH-1:0] req_op2,
    input  logic [1:0][3:0]       req_alu_op,
    output logic [1:0]            req_ready,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    input  logic                  rsp_ready,
    output logic [CNT_W-1:0]      grant_cnt0,
    output logic [CNT_W-1:0]      grant_cnt1
);

    sched_state_t     state, state_next;
    logic             rr_ptr;
    logic             grant;
    logic             grant_id;
    logic [WIDTH-1:0] op1_q, op2_q;
    logic [3:0]       op_q;
    logic             id_q;
    logic [WIDTH-1:0] alu_result;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Grants are only possible in IDLE, so completion and acceptance never share a cycle.
    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        grant      = 1'b0;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    grant               = 1'b1;
                    grant_id            = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
                    req_ready[grant_id] = 1'b1;
                    state_next          = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (grant) begin
                op1_q  <= req_op1[grant_id];
                op2_q  <= req_op2[grant_id];
                op_q   <= req_alu_op[grant_id];
                id_q   <= grant_id;
                rr_ptr <= ~grant_id;
            end
            if (state == EXEC) rsp_result <= alu_result;
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .alu_op (op_q),
        .op1    (op1_q),
        .op2    (op2_q),
        .result (alu_result)
    );

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            if (grant_id) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            else          grant_cnt0 <= grant_cnt0 + CNT_W'(1);
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Randomized scoreboard bench for alu_scheduler against a transaction-level reference model.
module tb_alu_scheduler;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0][WIDTH-1:0] req_op1;
    logic [1:0][WIDTH-1:0] req_op2;
    logic [1:0][3:0]       req_alu_op;
    logic [1:0]            req_ready;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_ready;
    logic [CNT_W-1:0]      grant_cnt0;
    logic [CNT_W-1:0]      grant_cnt1;

    alu_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_alu_op (req_alu_op),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ready  (rsp_ready),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] res;
        int               due;
    } exp_t;

    exp_t expq[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: held requests, arbitration pointer, busy window, grant tallies.
    logic [1:0]       pend_valid = 2'b00;
    logic [WIDTH-1:0] pend_a [2];
    logic [WIDTH-1:0] pend_b [2];
    logic [3:0]       pend_op [2];
    logic             m_ptr  = 1'b0;
    logic             m_busy = 1'b0;
    int               m_due  = 0;
    int               m_cnt0 = 0;
    int               m_cnt1 = 0;

    function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1101: return a ^ b;
            4'b1000: return a >> sh;
            4'b1001: return a << sh;
            4'b1010: return WIDTH'($signed(a) >>> sh);
            default: return a + b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    task automatic post(input int i, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [3:0] op);
        pend_valid[i] = 1'b1;
        pend_a[i]     = a;
        pend_b[i]     = b;
        pend_op[i]    = op;
    endtask

    // One clock cycle: drive inputs, predict the grant, update the model.
    task automatic applyStimulus(input logic rst_in, input logic rdy_in);
        logic [1:0] v;
        logic [1:0] exp_ready;
        int         g;
        @(negedge clk);
        rst = rst_in;
        v   = rst_in ? 2'b00 : pend_valid;
        req_valid = v;
        for (int i = 0; i < 2; i++) begin
            req_op1[i]    = pend_a[i];
            req_op2[i]    = pend_b[i];
            req_alu_op[i] = pend_op[i];
        end
        rsp_ready = rdy_in;
        #1;
        exp_ready = 2'b00;
        g = 0;
        if (!m_busy && v != 2'b00) begin
            if (v == 2'b11) g = int'(m_ptr);
            else            g = v[1] ? 1 : 0;
            exp_ready[g] = 1'b1;
        end
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        if (rst_in) begin
            expq.delete();
            m_busy = 1'b0;
            m_ptr  = 1'b0;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (m_busy && cyc >= m_due && rdy_in) m_busy = 1'b0;
            if (exp_ready != 2'b00) begin
                expq.push_back('{id: (g == 1), res: alu_ref(pend_op[g], pend_a[g], pend_b[g]),
                                 due: cyc + 2});
                m_busy        = 1'b1;
                m_due         = cyc + 2;
                m_ptr         = (g == 0);
                pend_valid[g] = 1'b0;
                if (g == 0) m_cnt0++;
                else        m_cnt1++;
            end
        end
    endtask

    task automatic runCycles(input int n, input logic rdy_in);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, rdy_in);
    endtask

    task automatic checkCounters();
`ifdef ALU_SCHED_STATS_EN
        checkOutput("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0 % (1 << CNT_W)));
        checkOutput("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1 % (1 << CNT_W)));
`else
        checkOutput("grant_cnt0", 64'(grant_cnt0), 64'd0);
        checkOutput("grant_cnt1", 64'(grant_cnt1), 64'd0);
`endif
    endtask

    // Monitor: every response cycle is compared against the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    if (cyc < expq[0].due) checkOutput("rsp_early", 64'(cyc), 64'(expq[0].due));
                    checkOutput("rsp_id", 64'(rsp_id), 64'(expq[0].id));
                    checkOutput("rsp_result", 64'(rsp_result), 64'(expq[0].res));
                    if (rsp_ready === 1'b1) void'(expq.pop_front());
                end
            end else if (expq.size() != 0 && cyc >= expq[0].due) begin
                checkOutput("rsp_late", 64'(rsp_valid), 64'd1);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_op1    = '0;
        req_op2    = '0;
        req_alu_op = '0;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend_a[i]  = '0;
            pend_b[i]  = '0;
            pend_op[i] = '0;
        end

        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset_rsp_result", 64'(rsp_result), 64'd0);
        checkCounters();

        post(0, 32'd5, 32'd3, ALU_ADD);
        runCycles(6, 1'b1);

        post(0, 32'd10, 32'd3, ALU_SUB);
        post(1, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
        runCycles(8, 1'b1);
        for (int r = 0; r < 2; r++) begin
            post(0, $urandom, $urandom, ALU_XOR);
            post(1, $urandom, $urandom, ALU_OR);
            runCycles(8, 1'b1);
        end

        post(0, 32'h8000_0000, 32'd4, ALU_SRA);
        runCycles(1, 1'b1);
        post(1, 32'd7, 32'd9, ALU_AND);
        post(0, 32'd1, 32'd31, ALU_SLL);
        runCycles(5, 1'b0);
        runCycles(10, 1'b1);

        post(0, 32'd100, 32'd1, ALU_SRL);
        post(1, 32'd200, 32'd2, ALU_ADD);
        runCycles(1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        if (!pend_valid[0]) post(0, 32'd11, 32'd22, ALU_ADD);
        if (!pend_valid[1]) post(1, 32'd33, 32'd44, ALU_SUB);
        runCycles(8, 1'b1);

        post(0, 32'd2, 32'd2, 4'b1111);
        runCycles(6, 1'b1);

        applyStimulus(1'b1, 1'b1);
        post(0, $urandom, $urandom, ALU_ADD);
        post(1, $urandom, $urandom, ALU_SUB);
        runCycles(8, 1'b1);
        post(0, $urandom, $urandom, ALU_AND);
        post(1, $urandom, $urandom, ALU_XOR);
        runCycles(8, 1'b1);
        post(0, $urandom, $urandom, ALU_SLT);
        runCycles(6, 1'b1);
        checkCounters();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++)
                if (!pend_valid[i] && $urandom_range(0, 2) == 0)
                    post(i, $urandom, $urandom, 4'($urandom_range(0, 15)));
            applyStimulus(1'b0, ($urandom_range(0, 9) < 7));
        end

        n = 0;
        while ((expq.size() != 0 || pend_valid != 2'b00) && n < 60) begin
            runCycles(1, 1'b1);
            n++;
        end
        checkOutput("drain_outstanding", 64'(expq.size()), 64'd0);
        checkCounters();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares one combinational `alu` instance between two requesters, e.g. the integer pipeline and a multi-cycle helper unit. Requests use a valid/ready handshake and are arbitrated round-robin. Operands are latched and the result is registered, with a tagged response channel that supports back-pressure. The block sits between the requesters and the shared ALU datapath and sequences every operation through a 3-state FSM.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width (fixed to 32 for the shared `alu`).
- `CNT_W`, 16: grant counter width (used only when stats are compiled in).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_op1`  in  2x32  per-requester first operand.
- `req_op2`  in  2x32  per-requester second operand.
- `req_alu_op`  in  2x4  per-requester ALU opcode.
- `req_ready`  out  2  one-hot accept; at most one bit high per cycle.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  1  index of the requester the response belongs to.
- `rsp_result`  out  32  ALU result.
- `rsp_ready`  in  1  consumer accepts response.
- `grant_cnt0`, `grant_cnt1`  out  CNT_W each  accepted-request counters (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no request is valid, stay in IDLE.
  - If exactly one request is valid, grant it.
  - If both are valid, grant requester `rr_ptr`.
  - On a grant: assert `req_ready[g]` combinationally in the same cycle, latch op1/op2/alu_op/id, set `rr_ptr <= ~g`, go to EXEC.
- EXEC: the shared `alu` is driven from the latched operands. Register its result into `rsp_result` and go to RESP.
- RESP: hold `rsp_valid=1` with `rsp_id` and `rsp_result` stable. When `rsp_ready=1`, go to IDLE. A new request is never accepted in the same cycle as response completion.
- Opcodes are passed through unchanged. Undefined codes yield op1+op2, per `alu` default behaviour.
- Requesters must hold valid and operands stable until ready. If `req_valid` drops before a grant, the request is simply not served.
- `rr_ptr` changes only on a grant. A lone requester can win repeatedly.

## Timing
- Accept in cycle N; `rsp_valid` rises in cycle N+2.
- Minimum issue interval is 3 cycles, plus any back-pressure cycles.
- Reset values:
  - state=IDLE, `rr_ptr=0` (requester 0 wins the first tie).
  - `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`.
  - Counters = 0.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is issued. Outputs take reset values in the next cycle.
- `req_ready` is 0 in EXEC and RESP regardless of `req_valid`.

## Configuration
- Macro: `ALU_SCHED_STATS_EN`.
- When defined:
  - `grant_cnt0` and `grant_cnt1` increment by 1 on each accepted request from that requester.
  - Counters wrap modulo 2^CNT_W.
  - Counters clear on `rst`.
- When undefined: the counter logic is omitted and both outputs are tied to 0.

## Structure
- Shared package `alu_pkg` contains:
  - ALU opcode constants: AND=0000, OR=0001, ADD=0010, SUB=0011, SLT=0111, XOR=1101, SRL=1000, SLL=1001, SRA=1010.
  - FSM state enum `sched_state_t`.
- Sub-module: one instance of the existing `alu`, driven only from latched operands. It is never driven directly from request ports.

## Test plan
- Reset, then req0 only: op1=5, op2=3, op=0010.
  - `req_ready=01` in the accept cycle.
  - Two cycles later: `rsp_valid=1`, `rsp_id=0`, `rsp_result=8`.
- Both valid from reset:
  - req0 SUB 10-3 is granted first and returns 7 with id 0.
  - req1 SLT op1=0xFFFFFFFF, op2=1 is granted next and returns 1 with id 1.
  - `rr_ptr` alternates on subsequent ties.
- Back-pressure: hold `rsp_ready=0` for 4 cycles on SRA op1=0x80000000, op2=4.
  - `rsp_result=0xF8000000` is held stable.
  - `req_ready=00` throughout.
  - The response completes in the cycle `rsp_ready=1`.
- Reset in EXEC: assert `rst` one cycle after an accept.
  - No `rsp_valid` appears.
  - The next tie grants requester 0.
- Stats (`ALU_SCHED_STATS_EN` defined): issue 3 req0 and 2 req1 operations.
  - `grant_cnt0=3`, `grant_cnt1=2`.
  - With the macro undefined, both counters read 0.
- Undefined opcode 1111 with op1=2, op2=2 returns 4.
